// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM command sequencer: geometry defaults and the
// sequencer state encoding.
package sram_pkg;
  localparam int SRAM_ROWS = 16;
  localparam int SRAM_COLS = 8;
  localparam int SRAM_AW   = $clog2(SRAM_ROWS);

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_SHIFT = 3'd1,
    SEQ_LOAD  = 3'd2,
    SEQ_GAP   = 3'd3,
    SEQ_WRITE = 3'd4,
    SEQ_READ  = 3'd5,
    SEQ_WAIT  = 3'd6,
    SEQ_RESP  = 3'd7
  } sram_seq_state_e;
endpackage

// File: rtl/sram_cmd_seq_if.sv
// Request/response port plus the SRAM serial-load pins of the command sequencer.
// slave = sequencer side, master = upstream requester / SRAM model side.
interface sram_cmd_seq_if
  import sram_pkg::*;
#(
  parameter int ROWS = SRAM_ROWS,
  parameter int COLS = SRAM_COLS
);
  localparam int AW = $clog2(ROWS);

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;
  logic            serial_in;
  logic            shift;
  logic            load;
  logic            w_en;
  logic            r_en;
  logic [AW-1:0]   addr;
  logic            data_valid;
  logic [COLS-1:0] data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, data_valid, data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, serial_in, shift, load, w_en, r_en, addr
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, data_valid, data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, serial_in, shift, load, w_en, r_en, addr
  );
endinterface

// File: rtl/sram_piso_ctrl.sv
// MSB-first serializer: on start, emits the word one bit per cycle with shift
// held high for COLS cycles; done marks the last bit.
module sram_piso_ctrl
  import sram_pkg::*;
#(
  parameter int COLS = SRAM_COLS
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            start_i,
  input  logic [COLS-1:0] word_i,
  output logic            shift_o,
  output logic            serial_o,
  output logic            done_o
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [COLS-1:0] sreg_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Word register is pure data; the busy flag gates everything it drives.
  always_ff @(posedge clk) begin
    if (start_i)
      sreg_q <= word_i;
    else if (busy_q)
      sreg_q <= sreg_q << 1;
  end

  assign shift_o  = busy_q;
  assign serial_o = busy_q & sreg_q[COLS-1];
  assign done_o   = busy_q && (cnt_q == CW'(COLS - 1));
endmodule

// File: rtl/sram_cmd_seq.sv
// Command sequencer turning parallel read/write requests into the SRAM serial-load
// protocol. Define SRAM_CMD_SEQ_TIMEOUT_EN to enable the read watchdog.
module sram_cmd_seq
  import sram_pkg::*;
#(
  parameter int ROWS       = SRAM_ROWS,
  parameter int COLS       = SRAM_COLS,
  parameter int RD_TIMEOUT = 16
) (
  input logic            clk,
  input logic            arst,
  sram_cmd_seq_if.slave  bus
);
  localparam int AW = $clog2(ROWS);

  localparam logic [2:0] S_IDLE  = SEQ_IDLE;
  localparam logic [2:0] S_SHIFT = SEQ_SHIFT;
  localparam logic [2:0] S_LOAD  = SEQ_LOAD;
  localparam logic [2:0] S_GAP   = SEQ_GAP;
  localparam logic [2:0] S_WRITE = SEQ_WRITE;
  localparam logic [2:0] S_READ  = SEQ_READ;
  localparam logic [2:0] S_WAIT  = SEQ_WAIT;
  localparam logic [2:0] S_RESP  = SEQ_RESP;

  if (RD_TIMEOUT < 1) begin : g_cfg_chk
    $error("sram_cmd_seq: RD_TIMEOUT must be at least 1");
  end

  logic [2:0]      state_q, state_d;
  logic            alive_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] rdata_q, rdata_d;
  logic            ready, accept;
  logic            piso_shift, piso_serial, piso_done;

`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // alive_q keeps req_ready low for the first cycle after reset release.
  assign ready  = alive_q && (state_q == S_IDLE);
  assign accept = ready && bus.req_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = bus.req_addr;
        state_d = bus.req_write ? S_SHIFT : S_READ;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_SHIFT: if (piso_done) state_d = S_LOAD;
      S_LOAD:  state_d = S_GAP;
      S_GAP:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_READ, S_WAIT: begin
        if (bus.data_valid) begin
          rdata_d = bus.data_out;
          state_d = S_RESP;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = S_WAIT;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
          if (state_q == S_WAIT) begin
            if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = S_RESP;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
`endif
        end
      end
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  sram_piso_ctrl #(.COLS(COLS)) u_piso (
    .clk      (clk),
    .arst     (arst),
    .start_i  (accept && bus.req_write),
    .word_i   (bus.req_wdata),
    .shift_o  (piso_shift),
    .serial_o (piso_serial),
    .done_o   (piso_done)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign bus.shift     = piso_shift;
  assign bus.serial_in = piso_serial;
  assign bus.load      = (state_q == S_LOAD);
  assign bus.w_en      = (state_q == S_WRITE);
  assign bus.r_en      = (state_q == S_READ);
  assign bus.addr      = addr_q;
endmodule

// File: tb/tb_sram_cmd_seq.sv
// Bench for sram_cmd_seq: transaction-level expectation model checked every cycle,
// plus directed scenarios with hand-computed cycle/data expectations.
module tb_sram_cmd_seq;
  localparam int ROWS       = 16;
  localparam int COLS       = 8;
  localparam int AW         = 4;
  localparam int RD_TIMEOUT = 16;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  sram_cmd_seq_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  sram_cmd_seq #(.ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pe     = 0;
  always @(posedge clk) pe <= pe + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- expectation model ----------------
  typedef struct packed {
    logic shift;
    logic serial;
    logic load;
    logic wen;
    logic ren;
  } strb_t;

  strb_t           q[$];
  strb_t           e_strb;
  logic            e_ready, e_rspv, e_err;
  logic [COLS-1:0] e_rdata;
  logic [AW-1:0]   e_addr;
  logic            m_alive, m_rdw, m_rdfirst, m_rsp, m_err, acc;
  logic [COLS-1:0] m_rdata;
  logic [AW-1:0]   m_addr;
  int              wcnt;

  always @(negedge clk) begin
    if (arst) begin
      chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.serial_in,
                            bus.shift, bus.load, bus.w_en, bus.r_en, bus.addr}, 32'd0);
      q.delete();
      e_strb = '0; e_ready = 0; e_rspv = 0; e_err = 0; e_rdata = '0; e_addr = '0;
      m_alive = 0; m_rdw = 0; m_rdfirst = 0; m_rsp = 0; m_err = 0; m_rdata = '0; m_addr = '0; wcnt = 0;
    end else begin
      chk("req_ready", bus.req_ready, e_ready);
      chk("strobes{shift,serial,load,w_en,r_en}",
          {bus.shift, bus.serial_in, bus.load, bus.w_en, bus.r_en}, e_strb);
      chk("addr", bus.addr, e_addr);
      chk("rsp_valid", bus.rsp_valid, e_rspv);
      chk("rsp_rdata", bus.rsp_rdata, e_rdata);
      chk("rsp_err", bus.rsp_err, e_err);
      // advance to the next cycle using the inputs that the coming edge samples
      acc = e_ready && bus.req_valid;
      if (m_rsp && bus.rsp_ready) m_rsp = 0;
      if (m_rdw) begin
        if (bus.data_valid) begin
          m_rsp = 1; m_rdata = bus.data_out; m_err = 0; m_rdw = 0;
        end else begin
          if (!m_rdfirst) wcnt++;
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
          if (wcnt == RD_TIMEOUT) begin
            m_rsp = 1; m_rdata = '0; m_err = 1; m_rdw = 0;
          end
`endif
        end
        m_rdfirst = 0;
      end
      if (acc) begin
        m_addr = bus.req_addr;
        if (bus.req_write) begin
          for (int i = 1; i <= COLS; i++) q.push_back(strb_t'{1'b1, bus.req_wdata[COLS-i], 1'b0, 1'b0, 1'b0});
          q.push_back(strb_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
          q.push_back(strb_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
          q.push_back(strb_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end else begin
          q.push_back(strb_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
          m_rdw = 1; m_rdfirst = 1; wcnt = 0;
        end
      end
      m_alive = 1;
      e_ready = m_alive && (q.size() == 0) && !m_rdw && !m_rsp;
      e_strb  = (q.size() != 0) ? q.pop_front() : strb_t'('0);
      e_rspv  = m_rsp;
      e_rdata = m_rdata;
      e_err   = m_err;
      e_addr  = m_addr;
    end
  end

  // ---------------- event log for directed expectations ----------------
  logic [COLS-1:0] ser_word, rsp_data;
  logic [AW-1:0]   wen_addr, ren_addr;
  logic            rsp_err_l;
  int shift_n, load_cyc, wen_cyc, ren_cyc, rsp_cyc, rsp_n, rdy_cyc;

  task automatic clear_logs();
    ser_word = '0; rsp_data = '0; wen_addr = '0; ren_addr = '0; rsp_err_l = 0;
    shift_n = 0; load_cyc = 0; wen_cyc = 0; ren_cyc = 0; rsp_cyc = 0; rsp_n = 0; rdy_cyc = 0;
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (bus.shift) begin ser_word = {ser_word[COLS-2:0], bus.serial_in}; shift_n++; end
      if (bus.load && load_cyc == 0) load_cyc = pe + 1;
      if (bus.w_en && wen_cyc == 0) begin wen_cyc = pe + 1; wen_addr = bus.addr; end
      if (bus.r_en && ren_cyc == 0) begin ren_cyc = pe + 1; ren_addr = bus.addr; end
      if (bus.rsp_valid) begin
        if (rsp_cyc == 0) begin rsp_cyc = pe + 1; rsp_data = bus.rsp_rdata; rsp_err_l = bus.rsp_err; end
        rsp_n++;
      end
      if (bus.req_ready && rdy_cyc == 0) rdy_cyc = pe + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                        input bit hold, output int t);
    bit got;
    got = 0;
    t = 0;
    bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin got = 1; t = pe + 1; end
    end
    chk("request_accepted", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t;
  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 0; bus.data_valid = 0; bus.data_out = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 arst = 1'b0;
    #1 chk("ready_low_at_release", bus.req_ready, 1'b0);
    @(posedge clk); #1 chk("ready_one_cycle_after_release", bus.req_ready, 1'b1);

    // write 0xA5 @5
    do_req(1'b1, 4'd5, 8'hA5, 0, t);
    repeat (13) @(posedge clk); #1;
    chk("wr_serial_word", ser_word, 8'hA5);
    chk("wr_shift_cycles", shift_n, 8);
    chk("wr_load_cycle", load_cyc, t + 9);
    chk("wr_wen_cycle", wen_cyc, t + 11);
    chk("wr_wen_addr", wen_addr, 4'd5);
    chk("wr_ready_cycle", rdy_cyc, t + 12);

    // stray data_valid while idle, then read @3 with data 0x3C at T+3, rsp_ready held low 3 cycles
    bus.data_valid = 1; bus.data_out = 8'h99;
    @(posedge clk); #1 bus.data_valid = 0;
    do_req(1'b0, 4'd3, 8'h00, 0, t);
    @(posedge clk); #1;
    @(posedge clk); #1 bus.data_valid = 1; bus.data_out = 8'h3C;
    @(posedge clk); #1 bus.data_valid = 0; bus.data_out = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.rsp_ready = 1;
    @(posedge clk); #1 bus.rsp_ready = 0;
    @(posedge clk); #1;
    chk("rd_ren_cycle", ren_cyc, t + 1);
    chk("rd_ren_addr", ren_addr, 4'd3);
    chk("rd_rsp_cycle", rsp_cyc, t + 4);
    chk("rd_rsp_data", rsp_data, 8'h3C);
    chk("rd_rsp_len", rsp_n, 4);
    chk("rd_ready_cycle", rdy_cyc, t + 8);

    // back-to-back: write 0xFF @2, read @2 with req_valid held
    do_req(1'b1, 4'd2, 8'hFF, 1, t);
    bus.req_write = 0; bus.req_addr = 4'd2;
    repeat (12) @(posedge clk); #1;
    bus.req_valid = 0; bus.data_valid = 1; bus.data_out = 8'h5A; bus.rsp_ready = 1;
    @(posedge clk); #1 bus.data_valid = 0;
    @(posedge clk); #1 bus.rsp_ready = 0;
    @(posedge clk); #1;
    chk("b2b_serial_word", ser_word, 8'hFF);
    chk("b2b_wen_cycle", wen_cyc, t + 11);
    chk("b2b_ren_cycle", ren_cyc, t + 13);
    chk("b2b_ren_addr", ren_addr, 4'd2);
    chk("b2b_rsp_data", rsp_data, 8'h5A);

    // reset during bit 4 of a write shift
    do_req(1'b1, 4'd7, 8'hC3, 0, t);
    repeat (4) @(posedge clk); #2 arst = 1'b1;
    #1 chk("midrst_outputs", {bus.req_ready, bus.rsp_valid, bus.serial_in, bus.shift, bus.load,
                             bus.w_en, bus.r_en, bus.addr}, 32'd0);
    @(posedge clk); #2 arst = 1'b0;
    clear_logs();
    #1 chk("midrst_ready_low_at_release", bus.req_ready, 1'b0);
    @(posedge clk); #1 chk("midrst_ready_after_release", bus.req_ready, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("midrst_no_load", load_cyc, 0);
    chk("midrst_no_wen", wen_cyc, 0);
    chk("midrst_no_shift", shift_n, 0);
    do_req(1'b1, 4'd9, 8'h0F, 0, t);
    repeat (13) @(posedge clk); #1;
    chk("post_rst_serial_word", ser_word, 8'h0F);
    chk("post_rst_load_cycle", load_cyc, t + 9);
    chk("post_rst_wen_cycle", wen_cyc, t + 11);
    chk("post_rst_wen_addr", wen_addr, 4'd9);

    // read with no data_valid
    do_req(1'b0, 4'd1, 8'h00, 0, t);
`ifdef SRAM_CMD_SEQ_TIMEOUT_EN
    repeat (20) @(posedge clk); #1;
    chk("tmo_rsp_cycle", rsp_cyc, t + 18);
    chk("tmo_rsp_err", rsp_err_l, 1'b1);
    chk("tmo_rsp_data", rsp_data, 8'h00);
    bus.rsp_ready = 1;
    @(posedge clk); #1 bus.rsp_ready = 0;
    @(posedge clk); #1;
`else
    repeat (100) @(posedge clk); #1;
    chk("wait_no_rsp_after_100", bus.rsp_valid, 1'b0);
    chk("wait_not_ready_after_100", bus.req_ready, 1'b0);
    bus.data_valid = 1; bus.data_out = 8'h77; bus.rsp_ready = 1;
    @(posedge clk); #1 bus.data_valid = 0;
    @(posedge clk); #1 bus.rsp_ready = 0;
    @(posedge clk); #1;
    chk("late_rsp_data", rsp_data, 8'h77);
    chk("late_rsp_err", rsp_err_l, 1'b0);
`endif
    chk("final_ready", bus.req_ready, 1'b1);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
